// File: rtl/panel_fsm_if.sv
// Front-panel bundle: button press pulses and sequencer completion in,
// panel state, program index and sequencer handshake out.
interface panel_fsm_if;
    logic       power_p;
    logic       mode_p;
    logic       start_p;
    logic       done;
    logic [1:0] state;
    logic [1:0] mode;
    logic       run_en;
    logic       start_req;
    logic       beep;

    modport master (
        output power_p, mode_p, start_p, done,
        input  state, mode, run_en, start_req, beep
    );

    modport slave (
        input  power_p, mode_p, start_p, done,
        output state, mode, run_en, start_req, beep
    );
endinterface

// File: rtl/panel_fsm.sv
// Washing-machine front-panel FSM: power, program select, run/pause.
// Optional idle auto-off is enabled by defining PANEL_AUTOOFF_EN.
module panel_fsm #(
    parameter int MODES        = 4,
    parameter int IDLE_TIMEOUT = 1_000_000_000
) (
    input  logic        clk,
    input  logic        rst,
    panel_fsm_if.slave  pnl
);

    typedef enum logic [1:0] {
        S_OFF   = 2'b00,
        S_IDLE  = 2'b01,
        S_RUN   = 2'b10,
        S_PAUSE = 2'b11
    } state_e;

    localparam logic [1:0] MODE_LAST = 2'(MODES - 1);

    if (MODES < 2 || MODES > 4 || IDLE_TIMEOUT < 2) begin : g_bad_cfg
        $error("panel_fsm: MODES must be 2..4 and IDLE_TIMEOUT at least 2");
    end

    state_e     state_q;
    logic [1:0] mode_q;
    logic       run_en_q;
    logic       start_req_q;
    logic       beep_q;

`ifdef PANEL_AUTOOFF_EN
    localparam logic [29:0] IDLE_LAST = 30'(IDLE_TIMEOUT - 1);
    logic [29:0] idle_cnt_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_OFF;
            mode_q      <= '0;
            run_en_q    <= 1'b0;
            start_req_q <= 1'b0;
            beep_q      <= 1'b0;
`ifdef PANEL_AUTOOFF_EN
            idle_cnt_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking defaults here are overridden by any later
            // assignment in this block, so pulses stay exactly one cycle wide.
            start_req_q <= 1'b0;
            beep_q      <= 1'b0;
`ifdef PANEL_AUTOOFF_EN
            idle_cnt_q  <= '0;
`endif
            case (state_q)
                S_OFF: begin
                    if (pnl.power_p) begin
                        state_q <= S_IDLE;
                        mode_q  <= '0;
                        beep_q  <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (pnl.power_p) begin
                        state_q <= S_OFF;
                        beep_q  <= 1'b1;
                    end else if (pnl.start_p) begin
                        state_q     <= S_RUN;
                        run_en_q    <= 1'b1;
                        start_req_q <= 1'b1;
                        beep_q      <= 1'b1;
                    end else if (pnl.mode_p) begin
                        mode_q <= (mode_q == MODE_LAST) ? 2'd0 : mode_q + 2'd1;
                        beep_q <= 1'b1;
`ifdef PANEL_AUTOOFF_EN
                    // Quiet IDLE cycle: count toward silent auto-off.
                    end else if (idle_cnt_q == IDLE_LAST) begin
                        state_q <= S_OFF;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 30'd1;
`endif
                    end
                end
                S_RUN: begin
                    if (pnl.power_p) begin
                        state_q  <= S_OFF;
                        run_en_q <= 1'b0;
                        beep_q   <= 1'b1;
                    end else if (pnl.done) begin
                        state_q  <= S_IDLE;
                        run_en_q <= 1'b0;
                        beep_q   <= 1'b1;
                    end else if (pnl.start_p) begin
                        state_q  <= S_PAUSE;
                        run_en_q <= 1'b0;
                        beep_q   <= 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (pnl.power_p) begin
                        state_q <= S_OFF;
                        beep_q  <= 1'b1;
                    end else if (pnl.done) begin
                        state_q <= S_IDLE;
                        beep_q  <= 1'b1;
                    end else if (pnl.start_p) begin
                        // Resume, not a new program start: no start_req.
                        state_q  <= S_RUN;
                        run_en_q <= 1'b1;
                        beep_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= S_OFF;
                    run_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign pnl.state     = state_q;
    assign pnl.mode      = mode_q;
    assign pnl.run_en    = run_en_q;
    assign pnl.start_req = start_req_q;
    assign pnl.beep      = beep_q;

endmodule

// File: tb/tb_panel_fsm.sv
// Bench for panel_fsm: directed scenarios plus randomized press bursts,
// all checked against an event-level model of the front panel.
module tb_panel_fsm;

    localparam int MODES   = 4;
    localparam int TIMEOUT = 16;
    localparam int OFF = 0, IDLE = 1, RUN = 2, PAUSE = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    panel_fsm_if pif ();

    panel_fsm #(
        .MODES        (MODES),
        .IDLE_TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pnl (pif)
    );

    int n_checks = 0;
    int n_errors = 0;

    int m_state;
    int m_mode;
    bit m_run;
    bit m_sreq;
    bit m_beep;
`ifdef PANEL_AUTOOFF_EN
    int m_quiet;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = OFF;
        m_mode  = 0;
        m_run   = 1'b0;
        m_sreq  = 1'b0;
        m_beep  = 1'b0;
`ifdef PANEL_AUTOOFF_EN
        m_quiet = 0;
`endif
    endtask

    // Pick the single highest-priority press that means something in the
    // current state, then apply its effect.
    task automatic model_step(input bit pw, input bit md, input bit st, input bit dn);
        int prev;
        int ev;
        prev = m_state;
        if (pw)                                   ev = 1;
        else if (dn && (prev == RUN || prev == PAUSE)) ev = 2;
        else if (st && prev != OFF)               ev = 3;
        else if (md && prev == IDLE)              ev = 4;
        else                                      ev = 0;
        m_sreq = 1'b0;
        m_beep = (ev != 0);
        case (ev)
            1: begin
                if (prev == OFF) begin
                    m_state = IDLE;
                    m_mode  = 0;
                end else begin
                    m_state = OFF;
                end
            end
            2: m_state = IDLE;
            3: begin
                m_state = (prev == RUN) ? PAUSE : RUN;
                m_sreq  = (prev == IDLE);
            end
            4: m_mode = (m_mode + 1) % MODES;
            default: ;
        endcase
`ifdef PANEL_AUTOOFF_EN
        if (ev == 0 && prev == IDLE) begin
            m_quiet++;
            if (m_quiet == TIMEOUT) begin
                m_state = OFF;
                m_quiet = 0;
            end
        end else begin
            m_quiet = 0;
        end
`endif
        m_run = (m_state == RUN);
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".state"},     pif.state,     m_state);
        check({tag, ".mode"},      pif.mode,      m_mode);
        check({tag, ".run_en"},    pif.run_en,    m_run);
        check({tag, ".start_req"}, pif.start_req, m_sreq);
        check({tag, ".beep"},      pif.beep,      m_beep);
    endtask

    // Called at a falling edge: drive one cycle of pulses, let the rising
    // edge happen, compare at the next falling edge.
    task automatic cycle(input bit pw, input bit md, input bit st, input bit dn, input string tag);
        pif.power_p = pw;
        pif.mode_p  = md;
        pif.start_p = st;
        pif.done    = dn;
        model_step(pw, md, st, dn);
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, ".state0"},  pif.state,     2'b00);
        check({tag, ".mode0"},   pif.mode,      2'b00);
        check({tag, ".run_en0"}, pif.run_en,    1'b0);
        check({tag, ".sreq0"},   pif.start_req, 1'b0);
        check({tag, ".beep0"},   pif.beep,      1'b0);
        model_reset();
        #1 rst = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, {tag, ".after"});
    endtask

    int exp_seq [5] = '{1, 2, 3, 0, 1};

    initial begin
        int len;
        int dens;
        bit pw, md, st, dn;

        pif.power_p = 1'b0;
        pif.mode_p  = 1'b0;
        pif.start_p = 1'b0;
        pif.done    = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #1 compare_all("reset");
        check("reset.state_const", pif.state, 2'b00);
        @(negedge clk);
        rst = 1'b0;

        cycle(1, 0, 0, 0, "pwr_on");
        check("pwr_on.state_const", pif.state, 2'b01);
        check("pwr_on.beep_const",  pif.beep,  1'b1);
        cycle(0, 0, 0, 0, "pwr_quiet");
        check("pwr_quiet.beep_const", pif.beep, 1'b0);

        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 0, 0, "mode_step");
            check("mode_seq", pif.mode, exp_seq[i]);
            check("mode_beep", pif.beep, 1'b1);
        end

        cycle(0, 0, 1, 0, "start");
        check("start.state_const", pif.state, 2'b10);
        check("start.sreq_const",  pif.start_req, 1'b1);
        cycle(0, 0, 1, 0, "pause");
        check("pause.state_const", pif.state, 2'b11);
        check("pause.sreq_const",  pif.start_req, 1'b0);
        cycle(0, 0, 1, 0, "resume");
        check("resume.state_const", pif.state, 2'b10);
        check("resume.sreq_const",  pif.start_req, 1'b0);
        cycle(0, 0, 0, 1, "done");
        check("done.state_const", pif.state, 2'b01);

        cycle(0, 0, 1, 0, "restart");
        cycle(0, 1, 1, 1, "coincide");
        check("coincide.state_const", pif.state, 2'b01);
        check("coincide.mode_const",  pif.mode,  2'd1);
        cycle(1, 0, 1, 0, "pwr_vs_start");
        check("pwr_vs_start.state_const", pif.state, 2'b00);

        cycle(1, 0, 0, 0, "tmo_on");
        for (int i = 1; i < 10; i++) cycle(0, 0, 0, 0, "tmo_wait");
        cycle(0, 1, 0, 0, "tmo_mode");
        for (int i = 1; i < TIMEOUT; i++) cycle(0, 0, 0, 0, "tmo_hold");
        check("tmo_hold.state_const", pif.state, 2'b01);
`ifdef PANEL_AUTOOFF_EN
        cycle(0, 0, 0, 0, "tmo_off");
        check("tmo_off.state_const", pif.state, 2'b00);
        check("tmo_off.beep_const",  pif.beep,  1'b0);
`else
        for (int i = 0; i < 100; i++) cycle(0, 0, 0, 0, "no_tmo");
        check("no_tmo.state_const", pif.state, 2'b01);
`endif

        async_reset("pre_rst");
        cycle(1, 0, 0, 0, "go_idle");
        cycle(0, 1, 0, 0, "go_m1");
        cycle(0, 1, 0, 0, "go_m2");
        cycle(0, 0, 1, 0, "go_run");
        check("go_run.state_const", pif.state, 2'b10);
        check("go_run.mode_const",  pif.mode,  2'd2);
        async_reset("mid_run_rst");

        // Bursts alternate between busy and fully quiet stretches so the
        // auto-off path is exercised alongside dense press traffic.
        for (int b = 0; b < 150; b++) begin
            len  = int'($urandom_range(1, 40));
            dens = int'($urandom_range(0, 3));
            for (int i = 0; i < len; i++) begin
                pw = (dens != 0) && ($urandom_range(0, 23) < dens);
                md = (dens != 0) && ($urandom_range(0, 7) < dens);
                st = (dens != 0) && ($urandom_range(0, 7) < dens);
                dn = (dens != 0) && ($urandom_range(0, 7) < dens);
                cycle(pw, md, st, dn, "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/panel_fsm.md
# panel_fsm

Front-panel control state machine for the washing machine. It consumes the single-cycle press pulses produced by the per-button debounce/edge stages, and tracks power, program selection and run/pause. It hands a one-cycle start request and a run enable to the downstream wash sequencer, and accepts the sequencer's completion signal.

## Interface
- `MODES`, default 4: number of wash programs; `mode` counts 0..MODES-1. Legal range 2..4.
- `IDLE_TIMEOUT`, default 1_000_000_000: cycles of inactivity in IDLE before auto power-off (10 s at 100 MHz). Minimum 2. Counter is 30 bits.
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `power_p` input 1: one-cycle press pulse from the power button stage.
- `mode_p` input 1: one-cycle press pulse from the mode button stage.
- `start_p` input 1: one-cycle press pulse from the start/pause button stage.
- `done` input 1: one-cycle pulse from the wash sequencer when the program completes.
- `state` output 2: 00 OFF, 01 IDLE, 10 RUN, 11 PAUSE.
- `mode` output 2: selected program index.
- `run_en` output 1: high exactly while `state` = RUN.
- `start_req` output 1: one-cycle pulse on each IDLE→RUN transition.
- `beep` output 1: one-cycle pulse for every accepted event.

## Operation
- All outputs are registered. Reset values: `state`=OFF, `mode`=0, `run_en`=0, `start_req`=0, `beep`=0, idle counter=0.
- An event is "accepted" if it changes `state` or `mode`. Ignored pulses produce no `beep` and have no side effect.
- Priority when events coincide in the same cycle: `power_p` > `done` > `start_p` > `mode_p`. Only the highest-priority applicable event is acted on; the others are dropped.
- OFF:
  - `power_p` → IDLE, with `mode` cleared to 0.
  - All other inputs, including `done`, are ignored.
- IDLE:
  - `power_p` → OFF.
  - `start_p` → RUN, with `start_req` pulsed.
  - `mode_p` → `mode` = `mode`+1, wrapping from MODES-1 to 0. State is unchanged.
  - Idle timeout → OFF. `mode` is retained.
- RUN:
  - `power_p` → OFF (abort).
  - `done` → IDLE. `mode` is retained.
  - `start_p` → PAUSE.
  - `mode_p` is ignored.
- PAUSE:
  - `power_p` → OFF.
  - `start_p` → RUN. No `start_req` (resume, not a new start).
  - `done` → IDLE.
  - `mode_p` is ignored.
- Idle counter:
  - Clears on entry to IDLE and on any accepted event.
  - Otherwise increments each IDLE cycle.
  - When it equals IDLE_TIMEOUT-1 and no accepted event occurs in that cycle, the next edge moves the state to OFF and clears the counter.
  - Held at 0 outside IDLE.
- The auto-off transition is not a button event: no `beep`.

## Timing
- Latency from an input pulse to `state`/`mode`/`run_en`/`start_req`/`beep` is 1 cycle. All of these update on the same edge.
- `start_req` and `beep` are exactly one cycle wide. Back-to-back accepted pulses on consecutive cycles produce back-to-back `beep` cycles.
- Auto-off happens exactly IDLE_TIMEOUT cycles after the edge that entered IDLE or accepted the last IDLE event.
- `rst` asserted mid-operation (any state, any counter value) forces all reset values immediately, without waiting for a clock edge. Operation resumes on the first edge after deassertion.

## Configuration
- Macro `PANEL_AUTOOFF_EN`.
- Defined: the idle counter and timeout transition are present as described above.
- Undefined: there is no counter logic. IDLE persists indefinitely, and `IDLE_TIMEOUT` is accepted but unused. All other behaviour is identical.

## Test plan
- Reset, then `power_p`: next cycle `state`=01, `mode`=0, `beep`=1 for one cycle, `run_en`=0.
- In IDLE with MODES=4, five `mode_p` pulses: `mode` steps 1, 2, 3, 0, 1, with five `beep` pulses.
- IDLE, `start_p`: `state`=10, `run_en`=1, `start_req` high for one cycle. Then `start_p` → 11 with no `start_req`. Then `start_p` → 10 with no `start_req`. Then `done` → 01.
- In RUN, `done`+`start_p`+`mode_p` in the same cycle: `state`=01, `mode` unchanged, one `beep`. In IDLE, `power_p`+`start_p` together: `state`=00.
- With IDLE_TIMEOUT=16 and the macro defined: enter IDLE, send `mode_p` at cycle 10; OFF occurs 16 cycles after the `mode_p` edge, with no `beep`. With the macro undefined: still IDLE after 100 cycles.
- Assert `rst` asynchronously while in RUN with `mode`=2: all outputs return to reset values before the next clock edge.
